clut_rle_decoder_gen: RTL and testbench
=======================================

Name: clut_rle_decoder_gen

Overview:
- Parametrised run-length / mosaic expander between the CLUT plane fetch and the CLUT lookup.
- Successor to the single-format 7-bit RLE stage. Adds:
  - CD-i RL3 dual-pixel decoding.
  - A runtime-selectable mode.
  - An explicit line-start resynchronisation input.
  - Optional run clipping at end of line.
- Consumes one byte per source transfer; emits one CLUT index per destination transfer.

Parameters:
DATA_W, 8, pixel/byte width; must be >= 8.
LINE_ST, 360, output pixels per line when st=1 (RL3: doubled).
LINE_NORM, 384, output pixels per line when st=0 (RL3: doubled).
CNT_W, 10, line-remaining counter width; must hold 2*LINE_NORM.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
st  in  1  standard-width line select
mode  in  2  0=passthrough, 1=RL7, 2=RL3, 3=mosaic
mf  in  2  mosaic factor; repeat count = 2<<mf (2,4,8,16)
line_start  in  1  single-cycle pulse at start of each line
src_pixel  in  DATA_W  source byte
src_write  in  1  source byte valid
src_strobe  out  1  source byte consumed
dst_pixel  out  DATA_W  output CLUT index
dst_write  out  1  output pixel valid
dst_strobe  in  1  sink accepts pixel
busy  out  1  state != SINGLE

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high.
- Handshake:
  - A transfer occurs on write && strobe.
  - src_strobe is only asserted together with src_write.
  - dst_write never depends combinationally on dst_strobe.
- During reset:
  - dst_write=0, src_strobe=0, dst_pixel=0, busy=0.
  - State=SINGLE, run count=0, line_rem loaded.
- line_rem:
  - Loaded with (st?LINE_ST:LINE_NORM), shifted left 1 in RL3, on reset, on line_start, or when it equals 0.
  - Otherwise decremented on each dst transfer.
- Priority: reset > line_start > normal.
  - line_start also forces state=SINGLE and count=0; any run in progress is dropped.
- Mode 0 (passthrough): dst_pixel=src_pixel, dst_write=src_write, src_strobe=dst_strobe; state held SINGLE.
- States: SINGLE, GET_COUNT, PAIR, RUN_LIMITED, RUN_EOL. Stored pixel register spd; RL3 pair p0/p1; phase bit ph.
- SINGLE:
  - RL7, bit7=0:
    - Zero-latency literal: dst_pixel={0,src[6:0]}, dst_write=src_write, src_strobe=dst_strobe.
    - Remain in SINGLE.
  - RL7, bit7=1: consume byte, spd={0,src[6:0]}, go to GET_COUNT.
  - RL3: on src_write, consume byte; p0=src[6:4], p1=src[2:0], ph=0.
    - bit7=0 → PAIR.
    - bit7=1 → GET_COUNT.
  - Mosaic: consume byte, spd=src, count=2<<mf, go to RUN_LIMITED.
- GET_COUNT: on src_write, consume byte.
  - N=0 → RUN_EOL.
  - Otherwise count=N → RUN_LIMITED.
  - RL7/mosaic count is in pixels; RL3 count is in pairs.
- PAIR:
  - Emit p0 then p1, zero-extended to DATA_W.
  - Go to SINGLE after the p1 transfer.
- RUN_LIMITED:
  - dst_write=(count!=0).
  - RL7/mosaic: count decrements per transfer.
  - RL3: ph toggles per transfer; count decrements on the p1 transfer.
  - count==0 → SINGLE, with a one-cycle bubble.
- RUN_EOL:
  - dst_write=(line_rem!=0); repeats spd, or alternates p0/p1 in RL3.
  - line_rem==0 → SINGLE.
- Mode change mid-run: undefined. Software changes mode only at line_start.
- Mode 0 and reset hold the FSM at SINGLE.

Optional Feature:
- Macro RLE_CLIP_EN.
  - Defined: in RUN_LIMITED and PAIR, the transfer that takes line_rem to 0 forces state=SINGLE and count=0. Runs never spill into the next line.
  - Undefined: runs continue across the line_rem reload. The residual count is emitted at the start of the next line unless line_start intervenes.

Test Plan:
- RL7, st=0, bytes 0x05, 0x85, 0x03, 0x07 → dst 0x05, 0x05×3, 0x07; src_strobe asserts on 4 transfers; one idle cycle after the run.
- RL7, bytes 0x81, 0x00, st=1 → 360 pixels of 0x01, then dst_write=0; busy falls when line_rem hits 0.
- RL3, bytes 0x35, 0x92, 0x02 → dst 3,5,1,2,1,2 (DATA_W zero-extended).
- Mosaic mf=2, bytes 0xAA, 0xBB → 0xAA×8, 0xBB×8; dst_strobe toggled randomly; no pixel lost or duplicated.
- line_start pulsed mid-run (0x83, 0x40 after 10 pixels) → state SINGLE next cycle; next byte decoded as new token; line_rem reloaded to 384.
- RLE_CLIP_EN, line_rem=3, run 0x84, 0x0A → 3 pixels of 0x04, then SINGLE. Without the macro, 7 further pixels appear on the next line.

Source files
------------

// File: rtl/clut_rle_decoder_gen.sv
// Run-length / mosaic expander between the CLUT plane fetch and the CLUT lookup.
// Optional end-of-line run clipping is enabled by defining RLE_CLIP_EN.
module clut_rle_decoder_gen #(
    parameter int DATA_W    = 8,
    parameter int LINE_ST   = 360,
    parameter int LINE_NORM = 384,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st,
    input  logic [1:0]        mode,
    input  logic [1:0]        mf,
    input  logic              line_start,
    input  logic [DATA_W-1:0] src_pixel,
    input  logic              src_write,
    output logic              src_strobe,
    output logic [DATA_W-1:0] dst_pixel,
    output logic              dst_write,
    input  logic              dst_strobe,
    output logic              busy
);

    // Handshake: a transfer happens on a cycle where write && strobe. src_strobe
    // is only raised alongside src_write; dst_write never looks at dst_strobe.

    localparam logic [1:0] M_PASS = 2'd0;
    localparam logic [1:0] M_RL7  = 2'd1;
    localparam logic [1:0] M_RL3  = 2'd2;

`ifdef RLE_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef enum logic [2:0] {
        SINGLE, GET_COUNT, PAIR, RUN_LIMITED, RUN_EOL
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   spd_q, spd_d;
    logic [2:0]          p0_q, p0_d, p1_q, p1_d;
    logic                ph_q, ph_d;
    logic [DATA_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]    line_rem_q, line_rem_d;
    logic [CNT_W-1:0]    line_len;
    logic [DATA_W-1:0]   run_pix;
    logic                dst_xfer;
    logic                last_of_line;

    always_comb begin
        dst_write  = 1'b0;
        src_strobe = 1'b0;
        dst_pixel  = '0;
        state_d    = state_q;
        spd_d      = spd_q;
        p0_d       = p0_q;
        p1_d       = p1_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;

        line_len = st ? CNT_W'(LINE_ST) : CNT_W'(LINE_NORM);
        if (mode == M_RL3)
            line_len = line_len << 1;

        run_pix      = (mode == M_RL3) ? DATA_W'(ph_q ? p1_q : p0_q) : spd_q;
        last_of_line = CLIP && (line_rem_q == CNT_W'(1));

        case (state_q)
            SINGLE: begin
                case (mode)
                    M_PASS: begin
                        dst_pixel  = src_pixel;
                        dst_write  = src_write;
                        src_strobe = src_write && dst_strobe;
                    end
                    M_RL7: begin
                        if (!src_pixel[7]) begin
                            dst_pixel  = DATA_W'(src_pixel[6:0]);
                            dst_write  = src_write;
                            src_strobe = src_write && dst_strobe;
                        end else begin
                            src_strobe = src_write;
                            if (src_write) begin
                                spd_d   = DATA_W'(src_pixel[6:0]);
                                state_d = GET_COUNT;
                            end
                        end
                    end
                    M_RL3: begin
                        src_strobe = src_write;
                        if (src_write) begin
                            p0_d    = src_pixel[6:4];
                            p1_d    = src_pixel[2:0];
                            ph_d    = 1'b0;
                            state_d = src_pixel[7] ? GET_COUNT : PAIR;
                        end
                    end
                    default: begin
                        src_strobe = src_write;
                        if (src_write) begin
                            spd_d   = src_pixel;
                            cnt_d   = DATA_W'(2) << mf;
                            state_d = RUN_LIMITED;
                        end
                    end
                endcase
            end
            GET_COUNT: begin
                src_strobe = src_write;
                if (src_write) begin
                    if (src_pixel == '0) begin
                        state_d = RUN_EOL;
                    end else begin
                        cnt_d   = src_pixel;
                        state_d = RUN_LIMITED;
                    end
                end
            end
            PAIR: begin
                dst_write = 1'b1;
                dst_pixel = run_pix;
                if (dst_strobe) begin
                    ph_d = !ph_q;
                    if (ph_q || last_of_line) begin
                        state_d = SINGLE;
                        ph_d    = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN_LIMITED: begin
                dst_write = (cnt_q != '0);
                dst_pixel = run_pix;
                if (cnt_q == '0) begin
                    state_d = SINGLE;
                end else if (dst_strobe) begin
                    // RL3 counts pairs: only the p1 half of a pair retires one.
                    if (mode == M_RL3) begin
                        ph_d = !ph_q;
                        if (ph_q)
                            cnt_d = cnt_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (last_of_line) begin
                        state_d = SINGLE;
                        cnt_d   = '0;
                    end
                end
            end
            RUN_EOL: begin
                dst_write = (line_rem_q != '0);
                dst_pixel = run_pix;
                if (dst_write && dst_strobe && mode == M_RL3)
                    ph_d = !ph_q;
                if (line_rem_q == '0)
                    state_d = SINGLE;
            end
            default: state_d = SINGLE;
        endcase

        if (mode == M_PASS)
            state_d = SINGLE;

        // A new line drops whatever run was in flight; nothing transfers this cycle.
        if (line_start) begin
            dst_write  = 1'b0;
            src_strobe = 1'b0;
            state_d    = SINGLE;
            cnt_d      = '0;
            ph_d       = 1'b0;
        end

        if (reset) begin
            dst_write  = 1'b0;
            src_strobe = 1'b0;
            dst_pixel  = '0;
        end

        dst_xfer = dst_write && dst_strobe;

        if (line_start || line_rem_q == '0)
            line_rem_d = line_len;
        else if (dst_xfer)
            line_rem_d = line_rem_q - 1'b1;
        else
            line_rem_d = line_rem_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SINGLE;
            spd_q      <= '0;
            p0_q       <= '0;
            p1_q       <= '0;
            ph_q       <= 1'b0;
            cnt_q      <= '0;
            line_rem_q <= line_len;
        end else begin
            state_q    <= state_d;
            spd_q      <= spd_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            line_rem_q <= line_rem_d;
        end
    end

    assign busy = !reset && (state_q != SINGLE);

endmodule

// File: tb/tb_clut_rle_decoder_gen.sv
// Self-checking bench for clut_rle_decoder_gen: vector table, corner-case
// sequences and randomized token streams against a token-level expansion model.
module tb_clut_rle_decoder_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       st;
    logic [1:0] mode;
    logic [1:0] mf;
    logic       line_start;
    logic [7:0] src_pixel;
    logic       src_write;
    logic       src_strobe;
    logic [7:0] dst_pixel;
    logic       dst_write;
    logic       dst_strobe;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int valid_pct = 100;
    int strobe_pct = 100;

    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];

    typedef struct packed {
        logic [1:0]       mode;
        logic [1:0]       mf;
        int               nb;
        logic [0:3][7:0]  b;
        int               ne;
        logic [0:15][7:0] e;
    } vec_t;

    vec_t vecs[8];

    clut_rle_decoder_gen dut (
        .clk        (clk),
        .reset      (reset),
        .st         (st),
        .mode       (mode),
        .mf         (mf),
        .line_start (line_start),
        .src_pixel  (src_pixel),
        .src_write  (src_write),
        .src_strobe (src_strobe),
        .dst_pixel  (dst_pixel),
        .dst_write  (dst_write),
        .dst_strobe (dst_strobe),
        .busy       (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic [1:0] f, input int nb,
                                input logic [0:3][7:0] b, input int ne,
                                input logic [0:15][7:0] e);
        vec_t v;
        v.mode = m; v.mf = f; v.nb = nb; v.b = b; v.ne = ne; v.e = e;
        return v;
    endfunction

    // Expands the queued source tokens into the pixel stream they describe.
    function automatic void model_decode(input logic [1:0] m, input logic [1:0] f);
        int i;
        int n;
        logic [7:0] b;
        logic [7:0] a0;
        logic [7:0] a1;
        i = 0;
        while (i < src_q.size()) begin
            b = src_q[i];
            i++;
            a0 = {5'd0, b[6:4]};
            a1 = {5'd0, b[2:0]};
            case (m)
                2'd0: exp_q.push_back(b);
                2'd1: begin
                    if (!b[7]) begin
                        exp_q.push_back({1'b0, b[6:0]});
                    end else begin
                        n = int'(src_q[i]);
                        i++;
                        repeat (n) exp_q.push_back({1'b0, b[6:0]});
                    end
                end
                2'd2: begin
                    if (!b[7]) begin
                        exp_q.push_back(a0);
                        exp_q.push_back(a1);
                    end else begin
                        n = int'(src_q[i]);
                        i++;
                        repeat (n) begin
                            exp_q.push_back(a0);
                            exp_q.push_back(a1);
                        end
                    end
                end
                default: repeat (2 << int'(f)) exp_q.push_back(b);
            endcase
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic pulse_line_start();
        @(posedge clk); #1;
        line_start = 1'b1;
        src_write  = 1'b0;
        dst_strobe = 1'b0;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic drive_cycle();
        @(posedge clk); #1;
        src_write  = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
        src_pixel  = src_write ? src_q[0] : 8'($urandom);
        dst_strobe = ($urandom_range(99) < strobe_pct);
    endtask

    task automatic sample_cycle();
        @(negedge clk);
        if (src_strobe) begin
            checks++;
            if (!src_write) begin
                errors++;
                $display("FAIL strobe_without_write: got src_strobe=1 expected 0");
            end
        end
        if (dst_write && dst_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_pixel: got %0h expected none", dst_pixel);
            end else begin
                check("pixel", {24'd0, dst_pixel}, {24'd0, exp_q.pop_front()});
            end
        end
        if (src_write && src_strobe)
            void'(src_q.pop_front());
    endtask

    task automatic run_stream(input int budget);
        int cyc;
        cyc = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            drive_cycle();
            sample_cycle();
            cyc++;
        end
        check("stream_done", {31'd0, (src_q.size() == 0 && exp_q.size() == 0)}, 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
            src_write  = 1'b0;
            dst_strobe = 1'b1;
            sample_cycle();
        end
        check("idle_after", {31'd0, busy}, 32'd0);
        src_q.delete();
        exp_q.delete();
    endtask

    task automatic feed_byte(input logic [7:0] b);
        @(posedge clk); #1;
        src_write  = 1'b1;
        src_pixel  = b;
        dst_strobe = 1'b1;
        @(negedge clk);
        check("feed_strobe", {31'd0, src_strobe}, 32'd1);
    endtask

    // Counts consecutive output pixels; leaves off at the first empty cycle.
    task automatic count_run(input logic [7:0] pix, output int n);
        int guard;
        guard = 0;
        n = 0;
        @(posedge clk); #1;
        src_write  = 1'b0;
        dst_strobe = 1'b1;
        forever begin
            @(negedge clk);
            if (!dst_write || guard >= 1000) break;
            if (dst_pixel !== pix) check("run_pixel", {24'd0, dst_pixel}, {24'd0, pix});
            n++;
            guard++;
            @(posedge clk); #1;
        end
    endtask

    task automatic random_case();
        int total;
        int n;
        logic [7:0] b;
        mode = 2'($urandom_range(3));
        mf   = 2'($urandom_range(3));
        st   = 1'($urandom_range(1));
        valid_pct  = $urandom_range(60, 100);
        strobe_pct = $urandom_range(60, 100);
        pulse_line_start();
        total = 0;
        while (total < 200) begin
            b = 8'($urandom);
            src_q.push_back(b);
            case (mode)
                2'd0: total += 1;
                2'd1: begin
                    if (b[7]) begin
                        n = $urandom_range(1, 20);
                        src_q.push_back(8'(n));
                        total += n;
                    end else total += 1;
                end
                2'd2: begin
                    if (b[7]) begin
                        n = $urandom_range(1, 10);
                        src_q.push_back(8'(n));
                        total += 2 * n;
                    end else total += 2;
                end
                default: total += 2 << int'(mf);
            endcase
        end
        model_decode(mode, mf);
        run_stream(6000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        reset = 1'b1; st = 1'b0; mode = 2'd1; mf = 2'd0; line_start = 1'b0;
        src_write = 1'b1; src_pixel = 8'h05; dst_strobe = 1'b1;

        vecs[0] = mk(2'd1, 2'd0, 4, {8'h05, 8'h85, 8'h03, 8'h07}, 5,
                     {8'h05, 8'h05, 8'h05, 8'h05, 8'h07, 88'h0});
        vecs[1] = mk(2'd2, 2'd0, 3, {8'h35, 8'h92, 8'h02, 8'h00}, 6,
                     {8'h03, 8'h05, 8'h01, 8'h02, 8'h01, 8'h02, 80'h0});
        vecs[2] = mk(2'd3, 2'd2, 2, {8'hAA, 8'hBB, 16'h0}, 16,
                     {{8{8'hAA}}, {8{8'hBB}}});
        vecs[3] = mk(2'd0, 2'd0, 4, {8'hFF, 8'h80, 8'h00, 8'h7F}, 4,
                     {8'hFF, 8'h80, 8'h00, 8'h7F, 96'h0});
        vecs[4] = mk(2'd3, 2'd0, 2, {8'h12, 8'hE3, 16'h0}, 4,
                     {8'h12, 8'h12, 8'hE3, 8'hE3, 96'h0});
        vecs[5] = mk(2'd1, 2'd0, 3, {8'h81, 8'h01, 8'h7E, 8'h00}, 2,
                     {8'h01, 8'h7E, 112'h0});
        vecs[6] = mk(2'd2, 2'd0, 3, {8'hF7, 8'h01, 8'h4B, 8'h00}, 4,
                     {8'h07, 8'h07, 8'h04, 8'h03, 96'h0});
        vecs[7] = mk(2'd3, 2'd3, 1, {8'h5A, 24'h0}, 16, {16{8'h5A}});

        // reset: outputs held quiet even with a literal offered
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dst_write", {31'd0, dst_write}, 32'd0);
        check("rst_src_strobe", {31'd0, src_strobe}, 32'd0);
        check("rst_dst_pixel", {24'd0, dst_pixel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        src_write = 1'b0;

        // vector table with randomized handshakes
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode;
            mf   = vecs[i].mf;
            st   = 1'b0;
            valid_pct  = $urandom_range(50, 100);
            strobe_pct = $urandom_range(50, 100);
            pulse_line_start();
            for (int j = 0; j < vecs[i].nb; j++) src_q.push_back(vecs[i].b[j]);
            for (int j = 0; j < vecs[i].ne; j++) exp_q.push_back(vecs[i].e[j]);
            run_stream(2000);
        end

        // RL7 run timing: zero-wait consumption, three pixels, one bubble
        mode = 2'd1; st = 1'b0;
        pulse_line_start();
        feed_byte(8'h85);
        check("tok_no_output", {31'd0, dst_write}, 32'd0);
        feed_byte(8'h03);
        check("count_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        src_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("run_write", {31'd0, dst_write}, 32'd1);
            check("run_value", {24'd0, dst_pixel}, 32'h05);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bubble_write", {31'd0, dst_write}, 32'd0);
        check("bubble_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("after_bubble_busy", {31'd0, busy}, 32'd0);

        // run to end of line, st=1
        st = 1'b1;
        pulse_line_start();
        feed_byte(8'h81);
        feed_byte(8'h00);
        count_run(8'h01, n);
        check("eol_len_st", n, 360);
        check("eol_stop", {31'd0, dst_write}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("eol_busy_fall", {31'd0, busy}, 32'd0);
        st = 1'b0;

        // line_start mid-run drops the run and reloads line_rem
        pulse_line_start();
        feed_byte(8'h83);
        feed_byte(8'h40);
        @(posedge clk); #1;
        src_write = 1'b0;
        dst_strobe = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("pre_ls_value", {24'd0, dst_pixel}, 32'h03);
            @(posedge clk); #1;
        end
        line_start = 1'b1;
        dst_strobe = 1'b0;
        @(posedge clk); #1;
        line_start = 1'b0;
        @(negedge clk);
        check("ls_busy", {31'd0, busy}, 32'd0);
        check("ls_dst_write", {31'd0, dst_write}, 32'd0);
        feed_byte(8'h81);
        feed_byte(8'h00);
        count_run(8'h01, n);
        check("eol_len_norm", n, 384);
        @(posedge clk); #1;

        // run hitting the end of the line with three pixels left
        mode = 2'd1; st = 1'b0;
        valid_pct = 100; strobe_pct = 100;
        pulse_line_start();
        for (int k = 0; k < 381; k++) src_q.push_back(8'($urandom_range(127)));
        model_decode(2'd1, 2'd0);
        run_stream(2000);
        src_q.push_back(8'h84);
        src_q.push_back(8'h0A);
`ifdef RLE_CLIP_EN
        repeat (3) exp_q.push_back(8'h04);
`else
        repeat (10) exp_q.push_back(8'h04);
`endif
        valid_pct = $urandom_range(60, 100);
        strobe_pct = $urandom_range(60, 100);
        run_stream(400);

        // randomized token streams
        for (int r = 0; r < 12; r++) random_case();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
